// File: rtl/inc_dec_if.sv
// ---------------------------------------------------------------------------
// inc_dec_if: operand/result bundle for the inc_dec unit.
//
//   in      operand (N bits)
//   mode    0 = increment, 1 = decrement
//   en      capture enable for the registered outputs
//   out     combinational result (N bits)
//   wrap    combinational: the step crossed the range boundary
//   out_q   registered result (N bits)
//   wrap_q  registered wrap
//   valid_q registered: out_q holds a captured result
//
// The master modport drives the operand side; the slave (the unit) returns
// both the combinational and the registered results.
// ---------------------------------------------------------------------------
interface inc_dec_if #(
  parameter int N = 4
);

  logic [N-1:0] in;
  logic         mode;
  logic         en;
  logic [N-1:0] out;
  logic         wrap;
  logic [N-1:0] out_q;
  logic         wrap_q;
  logic         valid_q;

  modport master (
    output in, mode, en,
    input  out, wrap, out_q, wrap_q, valid_q
  );

  modport slave (
    input  in, mode, en,
    output out, wrap, out_q, wrap_q, valid_q
  );

endinterface

// File: rtl/inc_dec.sv
// ---------------------------------------------------------------------------
// inc_dec: N-bit +/-1 step unit with a one-cycle registered copy.
//
// Parameters
//   N    data width in bits (N >= 1)
//   SAT  0 = modular wrap, 1 = saturate at the range ends
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous, active-low reset (clears the registered copy only)
//   bus    inc_dec_if slave:
//            in, mode, en          -> operand, direction, capture enable
//            out, wrap             <- combinational result and boundary flag
//            out_q, wrap_q, valid_q <- registered copy, updated when en=1
//
// The combinational path ignores clk and rst_n entirely. The registered path
// captures out/wrap on a rising edge with en=1 and holds otherwise.
// ---------------------------------------------------------------------------
module inc_dec #(
  parameter int N   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  inc_dec_if.slave     bus
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] step;
  logic         at_max;
  logic         at_min;
  logic         wrap_c;
  logic [N-1:0] out_c;

  logic [N-1:0] out_r;
  logic         wrap_r;
  logic         valid_r;

  // -------------------------------------------------------------------------
  // Combinational step. The boundary is detected on the operand itself, so
  // no carry bit is ever formed: in+1 / in-1 are plain N-bit modular results.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch forms.
    step   = '0;
    at_max = &bus.in;
    at_min = ~|bus.in;
    wrap_c = 1'b0;
    out_c  = '0;

    step   = bus.mode ? (bus.in - ONE) : (bus.in + ONE);
    wrap_c = bus.mode ? at_min : at_max;

    // Saturation pins the result at the end already reached: that end is
    // exactly the operand, so wrap still reports the boundary hit.
    if (SAT && wrap_c) begin
      out_c = bus.in;
    end else begin
      out_c = step;
    end
  end

  assign bus.out  = out_c;
  assign bus.wrap = wrap_c;

  // -------------------------------------------------------------------------
  // Registered copy. Reset clears it asynchronously and keeps it clear for as
  // long as rst_n is low; en=0 holds the last capture.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep all three flops sampling the same
      // pre-edge values, independent of statement order.
      out_r   <= '0;
      wrap_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (bus.en) begin
      out_r   <= out_c;
      wrap_r  <= wrap_c;
      valid_r <= 1'b1;
    end
  end

  assign bus.out_q   = out_r;
  assign bus.wrap_q  = wrap_r;
  assign bus.valid_q = valid_r;

endmodule

// File: tb/tb_inc_dec.sv
// ---------------------------------------------------------------------------
// tb_inc_dec: self-checking bench for inc_dec (N=4), one modular instance and
// one saturating instance driven with identical operands.
// ---------------------------------------------------------------------------
module tb_inc_dec;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  inc_dec_if #(.N(N)) if_mod ();
  inc_dec_if #(.N(N)) if_sat ();

  inc_dec #(.N(N), .SAT(1'b0)) dut_mod (.clk(clk), .rst_n(rst_n), .bus(if_mod));
  inc_dec #(.N(N), .SAT(1'b1)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit         sat;
    logic       mode;
    logic [3:0] in;
    logic [3:0] exp_out;
    logic       exp_wrap;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] in_v, input logic mode_v, input logic en_v);
    if_mod.in = in_v;  if_mod.mode = mode_v;  if_mod.en = en_v;
    if_sat.in = in_v;  if_sat.mode = mode_v;  if_sat.en = en_v;
  endtask

  // Reference: written from the boundary cases outward.
  function automatic logic [4:0] model(input logic [3:0] v, input logic m, input bit sat);
    logic [3:0] r;
    logic       w;
    if (m == 1'b0) begin
      w = (v == 4'hF);
      r = w ? (sat ? 4'hF : 4'h0) : v + 4'd1;
    end else begin
      w = (v == 4'h0);
      r = w ? (sat ? 4'h0 : 4'hF) : v - 4'd1;
    end
    return {w, r};
  endfunction

  initial begin
    logic [4:0] e;

    tbl[0]  = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'h7, 4'h8, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'h8, 4'h7, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'hF, 4'hF, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 4'hE, 4'hF, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 4'h1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 4'hF, 4'hE, 1'b0};

    // Reset held from time zero, through a clock edge with en=1.
    rst_n = 1'b0;
    drive(4'h3, 1'b0, 1'b1);
    #7;
    check("rst out_q",   32'(if_mod.out_q),   32'h0);
    check("rst wrap_q",  32'(if_mod.wrap_q),  32'h0);
    check("rst valid_q", 32'(if_mod.valid_q), 32'h0);
    check("rst comb out", 32'(if_mod.out),    32'h4);

    // Combinational vectors (reset still asserted: comb path must not care).
    foreach (tbl[i]) begin
      drive(tbl[i].in, tbl[i].mode, 1'b0);
      #1;
      check($sformatf("vec%0d out", i),
            32'(tbl[i].sat ? if_sat.out : if_mod.out), 32'(tbl[i].exp_out));
      check($sformatf("vec%0d wrap", i),
            32'(tbl[i].sat ? if_sat.wrap : if_mod.wrap), 32'(tbl[i].exp_wrap));
    end

    // Release reset away from the edge, then one capture.
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h7, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("cap out_q",   32'(if_mod.out_q),   32'h8);
    check("cap wrap_q",  32'(if_mod.wrap_q),  32'h0);
    check("cap valid_q", 32'(if_mod.valid_q), 32'h1);

    // en=0: hold over three edges while the operand changes.
    @(negedge clk);
    drive(4'h3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d out_q", k), 32'(if_mod.out_q), 32'h8);
      check($sformatf("hold%0d valid_q", k), 32'(if_mod.valid_q), 32'h1);
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_q",   32'(if_mod.out_q),   32'h0);
    check("async wrap_q",  32'(if_mod.wrap_q),  32'h0);
    check("async valid_q", 32'(if_mod.valid_q), 32'h0);
    drive(4'h5, 1'b1, 1'b1);
    #1;
    check("async comb out", 32'(if_mod.out), 32'h4);
    @(posedge clk); #1;
    check("rst held valid_q", 32'(if_mod.valid_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode changes between edges: the edge-time mode decides.
    drive(4'h0, 1'b0, 1'b1);
    #2;
    drive(4'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("modechg out_q",  32'(if_mod.out_q),  32'hF);
    check("modechg wrap_q", 32'(if_mod.wrap_q), 32'h1);
    check("modechg sat out_q", 32'(if_sat.out_q), 32'h0);

    // Exhaustive sweep, both instances, comb and registered.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 16; v++) begin
        @(negedge clk);
        drive(4'(v), 1'(m), 1'b1);
        #1;
        e = model(4'(v), 1'(m), 1'b0);
        check($sformatf("sw mod out m%0d v%0d", m, v),  32'(if_mod.out),  32'(e[3:0]));
        check($sformatf("sw mod wrap m%0d v%0d", m, v), 32'(if_mod.wrap), 32'(e[4]));
        e = model(4'(v), 1'(m), 1'b1);
        check($sformatf("sw sat out m%0d v%0d", m, v),  32'(if_sat.out),  32'(e[3:0]));
        check($sformatf("sw sat wrap m%0d v%0d", m, v), 32'(if_sat.wrap), 32'(e[4]));
        @(posedge clk); #1;
        e = model(4'(v), 1'(m), 1'b0);
        check($sformatf("sw mod out_q m%0d v%0d", m, v),  32'(if_mod.out_q),  32'(e[3:0]));
        check($sformatf("sw mod wrap_q m%0d v%0d", m, v), 32'(if_mod.wrap_q), 32'(e[4]));
        check($sformatf("sw mod valid_q m%0d v%0d", m, v), 32'(if_mod.valid_q), 32'h1);
        e = model(4'(v), 1'(m), 1'b1);
        check($sformatf("sw sat out_q m%0d v%0d", m, v),  32'(if_sat.out_q),  32'(e[3:0]));
        check($sformatf("sw sat wrap_q m%0d v%0d", m, v), 32'(if_sat.wrap_q), 32'(e[4]));
      end
    end

    $display("Test completed");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
